keypad_scan4: RTL and testbench
===============================

Name: keypad_scan4

Overview:
- 4x4 matrix keypad scanner: the input-side companion to the 4-digit seven-segment display driver in the CPU I/O subsystem.
- Drives the keypad rows one at a time, samples the columns, debounces the result, and latches key-press events into a read-to-clear register.
- The CPU reads that register through the memory-mapped I/O decoder using a one-cycle read strobe.

Parameters:
- SCAN_DIV, 2000: clk cycles per row slot; must be >= 4.
- DEBOUNCE_CNT, 4: consecutive identical frames required after a change before the stable map updates.
- REPEAT_FRAMES, 64: held-key repeat interval in frames; used only when KEY_REPEAT_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- key_col  in  4  keypad column inputs, active-low, externally pulled up, asynchronous to clk.
- KeyCtrl  in  1  CPU read strobe, one clk pulse; read-to-clear.
- key_row  out  4  row drive, active-low, exactly one bit low at any time.
- keyrdata  out  16  status word {valid, overflow, 10'b0, code[3:0]}.
- key_irq  out  1  equals the valid bit.

Behaviour:
- Reset (asynchronous) values:
  - key_row = 4'b1110; keyrdata = 16'h0000; key_irq = 0.
  - Slot counter, row index, stab_cnt, raw_map, prev_map and stable_map all cleared.
- Reset asserted mid-scan or mid-debounce discards all partial state; scanning restarts at row 0.
- Column input: key_col passes through a 2-flop synchronizer, then is inverted, so 1 = pressed.
- Scan timing:
  - slot_cnt counts 0..SCAN_DIV-1.
  - When slot_cnt == SCAN_DIV-1, the synchronized columns are written to raw_map[4r+3:4r], r = current row.
  - On that same edge the row index advances (3 wraps to 0) and key_row rotates so the next row is driven low.
- Frame: 4 slots = 4*SCAN_DIV clocks. A frame ends on the row-3 sample.
- Debounce, evaluated at each frame end (the comparison uses the new raw_map, including the row-3 bits captured on that edge):
  - If raw_map == prev_map, stab_cnt increments, saturating at DEBOUNCE_CNT; otherwise stab_cnt = 0.
  - prev_map <= raw_map.
  - On the frame where stab_cnt becomes DEBOUNCE_CNT, stable_map <= raw_map.
  - Net effect: a clean press is accepted DEBOUNCE_CNT+1 frames after it first appears in a frame.
- Press event: generated when stable_map goes from all-zero to non-zero.
  - code = index of the lowest set bit, i.e. row*4 + col.
  - Adding a key while others are held generates no event.
  - Release (stable_map returning to zero) generates no event and only re-arms detection.
- Event register (the only state visible to the CPU):
  - Event with valid=0: code <= new code, valid <= 1.
  - Event with valid=1: code is unchanged (first unread press is kept), overflow <= 1.
  - KeyCtrl with no event: valid <= 0, overflow <= 0; code is retained.
  - KeyCtrl and event in the same cycle: the event wins. valid = 1, code = new code, overflow = 0.
  - KeyCtrl while valid=0: no effect.
- keyrdata and key_irq are registered outputs. Latency from the event edge to valid/key_irq is 1 clk.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - A frame counter restarts at each press event.
  - While stable_map stays non-zero, a repeat event fires every REPEAT_FRAMES frames.
  - The repeat code is the lowest set bit of the current stable_map.
  - A repeat event follows the same valid/overflow rules as a press event.
  - Release stops repeating and clears the counter.
- Undefined: no repeat logic; exactly one event per press.

Test Plan:
(All scenarios use SCAN_DIV=4 and DEBOUNCE_CNT=2, so one frame is 16 clk.)
1. Reset, then idle with key_col=4'hF -> key_row cycles 1110,1101,1011,0111 every 4 clk; keyrdata stays 16'h0000 and key_irq stays 0 indefinitely.
2. Hold the row-2/column-1 key -> key_irq rises after 3 complete frames of the key visible; keyrdata=16'h8009. A KeyCtrl pulse then gives keyrdata=16'h0009 on the next edge.
3. Bounce: toggle column 1 every 5 clk for 4 frames, then hold it low -> no event during the bounce; one event, code 9, 3 frames after the hold begins.
4. Press key 0 and release; press key 5 without reading -> keyrdata=16'hC000 (code 0 kept, overflow set). KeyCtrl -> 16'h0000.
5. With valid=1 (code 3), assert KeyCtrl on the exact cycle a key-7 event fires -> keyrdata=16'h8007 with overflow 0.
6. Assert rst mid-frame while a key is held -> outputs clear immediately and key_row=4'b1110; with the key still held, re-detection occurs after 3 full frames following reset release. With KEY_REPEAT_EN and REPEAT_FRAMES=2, plus KeyCtrl after each event, the same code re-asserts every 32 clk while held.

Source files
------------

// File: rtl/keypad_scan4.sv
// keypad_scan4 -- 4x4 matrix keypad scanner with debounce and a read-to-clear
// key-event register for the CPU I/O subsystem.
//
// Optional feature macro: KEY_REPEAT_EN
//   Defined   : a held key re-fires its event every REPEAT_FRAMES frames.
//   Undefined : exactly one event per press.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   key_col   in   [3:0] column inputs, active-low, asynchronous to clk
//   KeyCtrl   in   CPU read strobe (one clk), clears valid/overflow
//   key_row   out  [3:0] row drive, active-low, one row low at a time
//   keyrdata  out  [15:0] {valid, overflow, 10'b0, code[3:0]}
//   key_irq   out  mirrors the valid bit
module keypad_scan4 #(
  parameter int SCAN_DIV      = 2000,
  parameter int DEBOUNCE_CNT  = 4,
  parameter int REPEAT_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_col,
  input  logic        KeyCtrl,
  output logic [3:0]  key_row,
  output logic [15:0] keyrdata,
  output logic        key_irq
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;

  // Column synchronizer; reset to "nothing pressed".
  logic [3:0] r_col_s1, r_col_s2;
  logic [3:0] w_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= key_col;
      r_col_s2 <= r_col_s1;
    end
  end

  assign w_col = ~r_col_s2;

  // Row scan
  logic [SW-1:0] r_slot_cnt;
  logic [1:0]    r_row;
  logic [3:0]    r_key_row;
  logic          w_slot_end, w_frame_end;

  assign w_slot_end  = (r_slot_cnt == SW'(SCAN_DIV - 1));
  assign w_frame_end = w_slot_end && (r_row == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_cnt <= '0;
      r_row      <= 2'd0;
      r_key_row  <= 4'b1110;
    end else if (w_slot_end) begin
      r_slot_cnt <= '0;
      r_row      <= r_row + 2'd1;
      r_key_row  <= {r_key_row[2:0], r_key_row[3]};
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  assign key_row = r_key_row;

  // Raw map with the current row's sample merged in, so the frame-end
  // comparison already sees the row-3 bits captured on that edge.
  logic [15:0]   r_raw_map, r_prev_map, r_stable_map;
  logic [15:0]   w_raw_next;
  logic [DW-1:0] r_stab_cnt;
  logic          w_match;

  always_comb begin
    w_raw_next = r_raw_map;
    w_raw_next[{r_row, 2'b00} +: 4] = w_col;
  end

  assign w_match = (w_raw_next == r_prev_map);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raw_map    <= '0;
      r_prev_map   <= '0;
      r_stable_map <= '0;
      r_stab_cnt   <= '0;
    end else begin
      if (w_slot_end)
        r_raw_map <= w_raw_next;
      if (w_frame_end) begin
        r_prev_map <= w_raw_next;
        if (!w_match)
          r_stab_cnt <= '0;
        else if (r_stab_cnt != DW'(DEBOUNCE_CNT))
          r_stab_cnt <= r_stab_cnt + 1'b1;
        // Accept only on the frame the counter reaches its limit.
        if (w_match && (r_stab_cnt == DW'(DEBOUNCE_CNT - 1)))
          r_stable_map <= w_raw_next;
      end
    end
  end

  // Press detection: stable map leaves zero. Fires in the cycle after the
  // stable map updates, so the register below lands one clock later.
  logic       r_stable_nz_d;
  logic       w_stable_nz, w_press, w_evt;
  logic [3:0] w_low_code;

  assign w_stable_nz = |r_stable_map;
  assign w_press     = w_stable_nz & ~r_stable_nz_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stable_nz_d <= 1'b0;
    else     r_stable_nz_d <= w_stable_nz;
  end

  // Lowest set bit = row*4 + col.
  always_comb begin
    w_low_code = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (r_stable_map[i]) w_low_code = 4'(i);
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES + 1) : 1;
  logic [RW-1:0] r_rep_cnt;
  logic          r_tick;   // frame end, aligned with the press cycle
  logic          w_repeat;

  assign w_repeat = r_tick && w_stable_nz && !w_press &&
                    (r_rep_cnt == RW'(REPEAT_FRAMES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick    <= 1'b0;
      r_rep_cnt <= '0;
    end else begin
      r_tick <= w_frame_end;
      if (!w_stable_nz || w_press)
        r_rep_cnt <= '0;
      else if (r_tick)
        r_rep_cnt <= w_repeat ? '0 : r_rep_cnt + 1'b1;
    end
  end

  assign w_evt = w_press | w_repeat;
`else
  assign w_evt = w_press;
`endif

  // Event register: first unread code is kept; a read in the same cycle as
  // an event lets the event through with overflow cleared.
  logic       r_valid, r_ovf;
  logic [3:0] r_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_code  <= 4'd0;
    end else if (w_evt) begin
      if (!r_valid || KeyCtrl) begin
        r_code  <= w_low_code;
        r_valid <= 1'b1;
        r_ovf   <= 1'b0;
      end else begin
        r_ovf   <= 1'b1;
      end
    end else if (KeyCtrl) begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end
  end

  assign keyrdata = {r_valid, r_ovf, 10'b0, r_code};
  assign key_irq  = r_valid;

endmodule

// File: tb/tb_keypad_scan4.sv
// Bench for keypad_scan4: directed scenarios plus random key maps, checked
// every cycle against a frame-level model of the keypad scanner.
module tb_keypad_scan4;
  localparam int SD = 4;
  localparam int DB = 2;
  localparam int RF = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_col;
  logic        KeyCtrl = 1'b0;
  logic [3:0]  key_row;
  logic [15:0] keyrdata;
  logic        key_irq;
  logic [15:0] keys = '0;   // physical keypad: bit 4*row+col = pressed

  int vectors = 0;
  int errors  = 0;

  keypad_scan4 #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_FRAMES(RF)) dut (
    .clk(clk), .rst(rst), .key_col(key_col), .KeyCtrl(KeyCtrl),
    .key_row(key_row), .keyrdata(keyrdata), .key_irq(key_irq)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a column reads low if a pressed key sits in a driven row.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!key_row[r]) key_col = key_col & ~keys[4*r +: 4];
  end

  // ---------------- behavioural model ----------------
  // The scanner sees the keypad two clocks late; every SD clocks one row is
  // sampled, every 4*SD clocks a frame completes. A frame map is accepted
  // when the last DB+1 frame maps (reset counts as one all-zero frame) agree.
  int          m_k;
  int          m_row;
  int          m_rep;
  logic [15:0] m_kh1, m_kh2, m_raw, m_stable, m_nxt;
  logic [15:0] m_fq[$];
  bit          m_same;
  logic        m_pend;
  logic [3:0]  m_pcode;
  logic        m_valid, m_ovf;
  logic [3:0]  m_code;

  function automatic logic [3:0] lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return 4'(i);
    return 4'd0;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_k = 0; m_kh1 = '0; m_kh2 = '0; m_raw = '0; m_stable = '0;
      m_fq.delete(); m_fq.push_back(16'h0000);
      m_pend = 1'b0; m_pcode = 4'd0; m_rep = 0;
      m_valid = 1'b0; m_ovf = 1'b0; m_code = 4'd0;
    end else begin
      m_k++;
      if (m_pend) begin
        if (!m_valid || KeyCtrl) begin
          m_code = m_pcode; m_valid = 1'b1; m_ovf = 1'b0;
        end else m_ovf = 1'b1;
        m_pend = 1'b0;
      end else if (KeyCtrl) begin
        m_valid = 1'b0; m_ovf = 1'b0;
      end
      if (m_k % SD == 0) begin
        m_row = ((m_k - 1) / SD) % 4;
        m_raw[4*m_row +: 4] = m_kh2[4*m_row +: 4];
        if (m_k % FR == 0) begin
          m_fq.push_back(m_raw);
          if (m_fq.size() > DB + 1) void'(m_fq.pop_front());
          m_nxt = m_stable;
          if (m_fq.size() == DB + 1) begin
            m_same = 1'b1;
            foreach (m_fq[i]) if (m_fq[i] != m_raw) m_same = 1'b0;
            if (m_same) m_nxt = m_raw;
          end
          if (m_stable == 16'h0 && m_nxt != 16'h0) begin
            m_pend = 1'b1; m_pcode = lowest(m_nxt); m_rep = 0;
          end
`ifdef KEY_REPEAT_EN
          else if (m_nxt != 16'h0) begin
            m_rep++;
            if (m_rep == RF) begin
              m_pend = 1'b1; m_pcode = lowest(m_nxt); m_rep = 0;
            end
          end else m_rep = 0;
`endif
          m_stable = m_nxt;
        end
      end
      m_kh2 = m_kh1;
      m_kh1 = keys;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_row(input int k);
    logic [3:0] r;
    r = 4'b0001 << ((k / SD) % 4);
    return ~r;
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("key_row",  key_row,  exp_row(m_k));
      chk("keyrdata", keyrdata, {m_valid, m_ovf, 10'b0, m_code});
      chk("key_irq",  key_irq,  m_valid);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd();
    KeyCtrl = 1'b1;
    @(negedge clk);
    KeyCtrl = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int lim, output int n);
    n = 0;
    while (!key_irq && n < lim) begin @(negedge clk); n++; end
    vectors++;
    if (!key_irq) begin
      errors++;
      $display("FAIL %s: key_irq 0 after %0d cycles, expected 1", name, lim);
    end
  endtask

  task automatic release_all();
    keys = '0;
    cyc(5 * FR);
    rd();
  endtask

  initial begin
    int n, sh, dur;
    logic [15:0] pat;

    // 1. reset and idle
    cyc(3);
    chk("rst_row",  key_row,  4'b1110);
    chk("rst_data", keyrdata, 16'h0000);
    chk("rst_irq",  key_irq,  1'b0);
    rst = 1'b0;
    cyc(10 * FR);
    chk("idle_data", keyrdata, 16'h0000);
    chk("idle_irq",  key_irq,  1'b0);

    // 2. row 2 / column 1 held
    keys = 16'h0200;
    wait_irq("s2_irq", 6 * FR, n);
    chk("s2_data", keyrdata, 16'h8009);
    rd();
    chk("s2_read", keyrdata, 16'h0009);
    release_all();

    // 3. bounce then hold
    for (int i = 0; i < 13; i++) begin
      keys = keys ^ 16'h0200;
      cyc(5);
    end
    chk("s3_no_evt", key_irq, 1'b0);
    keys = 16'h0200;
    wait_irq("s3_irq", 6 * FR, n);
    chk("s3_data", keyrdata, 16'h8009);
    rd();
    release_all();

    // 4. overflow keeps the first code
    keys = 16'h0001; cyc(5 * FR);
    keys = 16'h0000; cyc(5 * FR);
    keys = 16'h0020; cyc(5 * FR);
    keys = 16'h0000; cyc(5 * FR);
    chk("s4_ovf", keyrdata, 16'hC000);
    rd();
    chk("s4_read", keyrdata, 16'h0000);

    // 5. read strobe on the exact event cycle
    keys = 16'h0008; cyc(5 * FR);
    keys = 16'h0000; cyc(5 * FR);
    chk("s5_irq",  key_irq, 1'b1);
    chk("s5_code", keyrdata[3:0], 4'd3);
    keys = 16'h0080;
    n = 0;
    while (!m_pend && n < 6 * FR) begin @(negedge clk); n++; end
    vectors++;
    if (!m_pend) begin
      errors++;
      $display("FAIL s5_evt_wait: no key-7 event within %0d cycles", 6 * FR);
    end
    rd();
    chk("s5_data", keyrdata, 16'h8007);
    rd();
    release_all();

    // 6. reset mid-frame with a key held
    keys = 16'h0200; cyc(5 * FR);
    chk("s6_pre", key_irq, 1'b1);
    cyc(7);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_data", keyrdata, 16'h0000);
    chk("s6_rst_row",  key_row,  4'b1110);
    chk("s6_rst_irq",  key_irq,  1'b0);
    cyc(3);
    rst = 1'b0;
    cyc(3 * FR);
    chk("s6_before", key_irq, 1'b0);
    cyc(1);
    chk("s6_redetect", keyrdata, 16'h8009);
`ifdef KEY_REPEAT_EN
    for (int j = 0; j < 2; j++) begin
      rd();
      n = 0;
      while (!key_irq && n < 4 * FR) begin @(negedge clk); n++; end
      chk("s6_rep_gap",  n + 1, 32);
      chk("s6_rep_data", keyrdata, 16'h8009);
    end
`else
    rd();
    cyc(4 * FR);
    chk("s6_no_repeat", key_irq, 1'b0);
`endif
    release_all();

    // random key maps and read strobes
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 4))
        0: pat = 16'h0000;
        1: begin sh = $urandom_range(0, 15); pat = 16'(1) << sh; end
        2: begin
             sh = $urandom_range(0, 15); pat = 16'(1) << sh;
             sh = $urandom_range(0, 15); pat = pat | (16'(1) << sh);
           end
        default: pat = 16'($urandom);
      endcase
      keys = pat;
      dur = $urandom_range(3, 6 * FR);
      for (int c = 0; c < dur; c++) begin
        KeyCtrl = !KeyCtrl && ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      KeyCtrl = 1'b0;
    end
    keys = '0;
    cyc(5 * FR);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

endmodule
